// File: rtl/axil_master_bridge_if.sv
// Signal bundle between the core-side request/response port, the bridge and an AXI-lite responder.
// The master modport is the bridge's view; the slave modport is the core-plus-responder side.
interface axil_master_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [STRB_W-1:0] req_wstrb;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready
  );
endinterface

// File: rtl/axil_master_bridge.sv
// Single-outstanding load/store request port to AXI-lite initiator.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high; valid never drops before that.
module axil_master_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  axil_master_bridge_if.master  bus,
  output logic [2:0]            dbg_state_o
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_RESP = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] araddr_q, awaddr_q;
  logic [DATA_W-1:0] wdata_q, rsp_rdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
  logic              aw_done_q, w_done_q, rsp_valid_q, rsp_err_q;
  logic              aw_done_d, w_done_d;

  // A write channel counts as done once its handshake has happened, including this cycle's.
  always_comb begin
    aw_done_d = aw_done_q | (awvalid_q & bus.awready);
    w_done_d  = w_done_q  | (wvalid_q  & bus.wready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      araddr_q    <= '0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            if (bus.req_we) begin
              awaddr_q  <= bus.req_addr;
              wdata_q   <= bus.req_wdata;
              wstrb_q   <= bus.req_wstrb;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              state_q   <= S_WR_REQ;
            end else begin
              araddr_q  <= bus.req_addr;
              arvalid_q <= 1'b1;
              state_q   <= S_RD_ADDR;
            end
          end
        end
        S_RD_ADDR: begin
          if (bus.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (bus.rvalid) begin
            rready_q    <= 1'b0;
            rsp_rdata_q <= bus.rdata;
            rsp_err_q   <= (bus.rresp != 2'b00);
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end
        end
        S_WR_REQ: begin
          aw_done_q <= aw_done_d;
          w_done_q  <= w_done_d;
          if (awvalid_q && bus.awready) awvalid_q <= 1'b0;
          if (wvalid_q && bus.wready)   wvalid_q  <= 1'b0;
          if (aw_done_d && w_done_d) begin
            bready_q <= 1'b1;
            state_q  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (bus.bvalid) begin
            bready_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= (bus.bresp != 2'b00);
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // req_ready is gated by rst_n so it reads low for the whole reset assertion.
  assign bus.req_ready = (state_q == S_IDLE) & rst_n;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.araddr    = araddr_q;
  assign bus.arvalid   = arvalid_q;
  assign bus.rready    = rready_q;
  assign bus.awaddr    = awaddr_q;
  assign bus.awvalid   = awvalid_q;
  assign bus.wdata     = wdata_q;
  assign bus.wstrb     = wstrb_q;
  assign bus.wvalid    = wvalid_q;
  assign bus.bready    = bready_q;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_axil_master_bridge.sv
// Directed bench for axil_master_bridge: the bench plays both the core and the AXI-lite responder
// cycle by cycle and checks every output against hand-computed values.
module tb_axil_master_bridge;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] dbg_state;
  int         n_checks = 0;
  int         n_fail = 0;

  axil_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  axil_master_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.req_valid = 0; bus.req_we = 0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_wstrb = '0;
    bus.rsp_ready = 0; bus.arready = 0; bus.rdata = '0; bus.rresp = 2'b00; bus.rvalid = 0;
    bus.awready = 0; bus.wready = 0; bus.bresp = 2'b00; bus.bvalid = 0;
  endtask

  task automatic test_reset();
    logic [6:0] hs;
    drive_idle();
    rst_n = 1'b0;
    repeat (3) step();
    hs = {bus.req_ready, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready, bus.rsp_valid};
    n_checks++; if (hs !== 7'b0) begin n_fail++; $display("FAIL rst_handshakes: got %b, expected 0000000", hs); end
    n_checks++; if (bus.araddr !== 32'h0) begin n_fail++; $display("FAIL rst_araddr: got %h, expected 0", bus.araddr); end
    n_checks++; if (bus.awaddr !== 32'h0) begin n_fail++; $display("FAIL rst_awaddr: got %h, expected 0", bus.awaddr); end
    n_checks++; if (bus.wdata !== 32'h0) begin n_fail++; $display("FAIL rst_wdata: got %h, expected 0", bus.wdata); end
    n_checks++; if (bus.wstrb !== 4'h0) begin n_fail++; $display("FAIL rst_wstrb: got %h, expected 0", bus.wstrb); end
    n_checks++; if ({bus.rsp_rdata, bus.rsp_err} !== 33'h0) begin n_fail++; $display("FAIL rst_rsp: got %h/%b, expected 0/0", bus.rsp_rdata, bus.rsp_err); end
    n_checks++; if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL rst_state: got %0d, expected 0", dbg_state); end
    rst_n = 1'b1;
    step();
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_req_ready: got %b, expected 1", bus.req_ready); end
  endtask

  task automatic test_read_zero_wait();
    bus.req_valid = 1; bus.req_we = 0; bus.req_addr = 32'h8000_0000;
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rd0_req_ready: got %b, expected 1", bus.req_ready); end
    step();
    bus.req_valid = 0;
    n_checks++; if (bus.arvalid !== 1'b1) begin n_fail++; $display("FAIL rd0_arvalid_c1: got %b, expected 1", bus.arvalid); end
    n_checks++; if (bus.araddr !== 32'h8000_0000) begin n_fail++; $display("FAIL rd0_araddr: got %h, expected 80000000", bus.araddr); end
    n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL rd0_req_ready_busy: got %b, expected 0", bus.req_ready); end
    bus.arready = 1;
    step();
    bus.arready = 0;
    n_checks++; if ({bus.arvalid, bus.rready} !== 2'b01) begin n_fail++; $display("FAIL rd0_rready_c2: got ar/r=%b, expected 01", {bus.arvalid, bus.rready}); end
    bus.rvalid = 1; bus.rdata = 32'h0000_0413; bus.rresp = 2'b00;
    step();
    bus.rvalid = 0; bus.rdata = 32'h0;
    n_checks++; if ({bus.rsp_valid, bus.rready} !== 2'b10) begin n_fail++; $display("FAIL rd0_rsp_valid_c3: got rsp/r=%b, expected 10", {bus.rsp_valid, bus.rready}); end
    n_checks++; if (bus.rsp_rdata !== 32'h0000_0413) begin n_fail++; $display("FAIL rd0_rdata: got %h, expected 00000413", bus.rsp_rdata); end
    n_checks++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL rd0_err: got %b, expected 0", bus.rsp_err); end
    bus.rsp_ready = 1;
    step();
    bus.rsp_ready = 0;
    n_checks++; if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin n_fail++; $display("FAIL rd0_back_idle: got rsp/req_ready=%b, expected 01", {bus.rsp_valid, bus.req_ready}); end
  endtask

  task automatic test_read_latency();
    bus.req_valid = 1; bus.req_we = 0; bus.req_addr = 32'h8000_0040;
    step();
    bus.req_valid = 0; bus.req_addr = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if ({bus.arvalid, bus.araddr} !== {1'b1, 32'h8000_0040}) begin n_fail++; $display("FAIL rdlat_ar_hold%0d: got %b/%h, expected 1/80000040", i, bus.arvalid, bus.araddr); end
      step();
    end
    n_checks++; if ({bus.arvalid, bus.araddr} !== {1'b1, 32'h8000_0040}) begin n_fail++; $display("FAIL rdlat_ar_at_ready: got %b/%h, expected 1/80000040", bus.arvalid, bus.araddr); end
    bus.arready = 1;
    step();
    bus.arready = 0;
    n_checks++; if ({bus.arvalid, bus.rready} !== 2'b01) begin n_fail++; $display("FAIL rdlat_ar_done: got ar/r=%b, expected 01", {bus.arvalid, bus.rready}); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if ({bus.rready, bus.rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL rdlat_r_wait%0d: got r/rsp=%b, expected 10", i, {bus.rready, bus.rsp_valid}); end
      step();
    end
    bus.rvalid = 1; bus.rdata = 32'hCAFE_0001; bus.rresp = 2'b00;
    step();
    bus.rvalid = 0; bus.rdata = 32'h0;
    n_checks++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {2'b10, 32'hCAFE_0001}) begin n_fail++; $display("FAIL rdlat_rsp: got %b/%b/%h, expected 1/0/cafe0001", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
    bus.rsp_ready = 1;
    step();
    bus.rsp_ready = 0;
  endtask

  task automatic test_write_split();
    bus.req_valid = 1; bus.req_we = 1; bus.req_addr = 32'h8000_0010; bus.req_wdata = 32'hDEAD_BEEF; bus.req_wstrb = 4'hF;
    step();
    bus.req_valid = 0; bus.req_we = 0; bus.req_wdata = 32'h0;
    n_checks++; if ({bus.awvalid, bus.wvalid} !== 2'b11) begin n_fail++; $display("FAIL wr_valid_c1: got aw/w=%b, expected 11", {bus.awvalid, bus.wvalid}); end
    n_checks++; if ({bus.awaddr, bus.wdata, bus.wstrb} !== {32'h8000_0010, 32'hDEAD_BEEF, 4'hF}) begin n_fail++; $display("FAIL wr_payload: got %h/%h/%h, expected 80000010/deadbeef/f", bus.awaddr, bus.wdata, bus.wstrb); end
    bus.wready = 1;
    step();
    bus.wready = 0;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if ({bus.awvalid, bus.wvalid, bus.bready, bus.awaddr} !== {3'b100, 32'h8000_0010}) begin n_fail++; $display("FAIL wr_aw_wait%0d: got aw/w/b=%b addr=%h, expected 100/80000010", i, {bus.awvalid, bus.wvalid, bus.bready}, bus.awaddr); end
      if (i == 2) bus.awready = 1;
      step();
    end
    bus.awready = 0;
    n_checks++; if ({bus.awvalid, bus.wvalid, bus.bready} !== 3'b001) begin n_fail++; $display("FAIL wr_bready: got aw/w/b=%b, expected 001", {bus.awvalid, bus.wvalid, bus.bready}); end
    bus.bvalid = 1; bus.bresp = 2'b00;
    step();
    bus.bvalid = 0;
    n_checks++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.bready} !== {2'b10, 32'h0, 1'b0}) begin n_fail++; $display("FAIL wr_rsp: got %b/%b/%h b=%b, expected 1/0/0 b=0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.bready); end
    bus.rsp_ready = 1;
    step();
    bus.rsp_ready = 0;
  endtask

  task automatic test_write_aw_first();
    bus.req_valid = 1; bus.req_we = 1; bus.req_addr = 32'h0000_0100; bus.req_wdata = 32'h1234_5678; bus.req_wstrb = 4'h3;
    step();
    bus.req_valid = 0; bus.req_we = 0;
    bus.awready = 1;
    step();
    bus.awready = 0;
    n_checks++; if ({bus.awvalid, bus.wvalid, bus.bready} !== 3'b010) begin n_fail++; $display("FAIL wraw_after_aw: got aw/w/b=%b, expected 010", {bus.awvalid, bus.wvalid, bus.bready}); end
    step();
    n_checks++; if ({bus.wvalid, bus.wdata, bus.wstrb} !== {1'b1, 32'h1234_5678, 4'h3}) begin n_fail++; $display("FAIL wraw_w_hold: got %b/%h/%h, expected 1/12345678/3", bus.wvalid, bus.wdata, bus.wstrb); end
    bus.wready = 1;
    step();
    bus.wready = 0;
    n_checks++; if ({bus.awvalid, bus.wvalid, bus.bready} !== 3'b001) begin n_fail++; $display("FAIL wraw_bready: got aw/w/b=%b, expected 001", {bus.awvalid, bus.wvalid, bus.bready}); end
    bus.bvalid = 1; bus.bresp = 2'b00;
    step();
    bus.bvalid = 0;
    bus.rsp_ready = 1;
    step();
    bus.rsp_ready = 0;
  endtask

  task automatic test_error_resp();
    bus.req_valid = 1; bus.req_we = 0; bus.req_addr = 32'h4000_0000;
    step();
    bus.req_valid = 0; bus.arready = 1;
    step();
    bus.arready = 0; bus.rvalid = 1; bus.rdata = 32'h0000_0055; bus.rresp = 2'b10;
    step();
    bus.rvalid = 0; bus.rresp = 2'b00;
    n_checks++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {2'b11, 32'h55}) begin n_fail++; $display("FAIL err_read: got %b/%b/%h, expected 1/1/00000055", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
    bus.rsp_ready = 1;
    step();
    bus.rsp_ready = 0;
    bus.req_valid = 1; bus.req_we = 1; bus.req_addr = 32'h4000_0004; bus.req_wdata = 32'hA5A5_A5A5; bus.req_wstrb = 4'h0;
    step();
    bus.req_valid = 0; bus.req_we = 0;
    n_checks++; if ({bus.awvalid, bus.wvalid, bus.wstrb} !== {2'b11, 4'h0}) begin n_fail++; $display("FAIL err_wstrb0: got aw/w=%b strb=%h, expected 11/0", {bus.awvalid, bus.wvalid}, bus.wstrb); end
    bus.awready = 1; bus.wready = 1;
    step();
    bus.awready = 0; bus.wready = 0;
    n_checks++; if ({bus.awvalid, bus.wvalid, bus.bready} !== 3'b001) begin n_fail++; $display("FAIL err_same_cycle: got aw/w/b=%b, expected 001", {bus.awvalid, bus.wvalid, bus.bready}); end
    bus.bvalid = 1; bus.bresp = 2'b11;
    step();
    bus.bvalid = 0; bus.bresp = 2'b00;
    n_checks++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {2'b11, 32'h0}) begin n_fail++; $display("FAIL err_write: got %b/%b/%h, expected 1/1/0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
    bus.rsp_ready = 1;
    step();
    bus.rsp_ready = 0;
  endtask

  task automatic test_back_to_back();
    bus.req_valid = 1; bus.req_we = 0; bus.req_addr = 32'h2000_0000;
    step();
    bus.req_valid = 0; bus.arready = 1;
    step();
    bus.arready = 0; bus.rvalid = 1; bus.rdata = 32'h0BAD_F00D;
    step();
    bus.rvalid = 0; bus.rdata = 32'h0;
    bus.req_valid = 1; bus.req_we = 0; bus.req_addr = 32'h3000_0004;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if ({bus.rsp_valid, bus.rsp_rdata, bus.req_ready, bus.arvalid} !== {1'b1, 32'h0BAD_F00D, 2'b00}) begin n_fail++; $display("FAIL b2b_hold%0d: got rsp=%b data=%h req_ready=%b ar=%b, expected 1/0badf00d/0/0", i, bus.rsp_valid, bus.rsp_rdata, bus.req_ready, bus.arvalid); end
      step();
    end
    bus.rsp_ready = 1;
    step();
    bus.rsp_ready = 0;
    n_checks++; if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin n_fail++; $display("FAIL b2b_idle: got rsp/req_ready=%b, expected 01", {bus.rsp_valid, bus.req_ready}); end
    step();
    bus.req_valid = 0;
    n_checks++; if ({bus.arvalid, bus.araddr} !== {1'b1, 32'h3000_0004}) begin n_fail++; $display("FAIL b2b_next_ar: got %b/%h, expected 1/30000004", bus.arvalid, bus.araddr); end
    bus.arready = 1;
    step();
    bus.arready = 0; bus.rvalid = 1; bus.rdata = 32'h0000_0077;
    step();
    bus.rvalid = 0; bus.rdata = 32'h0;
    n_checks++; if ({bus.rsp_valid, bus.rsp_rdata} !== {1'b1, 32'h77}) begin n_fail++; $display("FAIL b2b_next_rsp: got %b/%h, expected 1/00000077", bus.rsp_valid, bus.rsp_rdata); end
    bus.rsp_ready = 1;
    step();
    bus.rsp_ready = 0;
  endtask

  task automatic test_reset_mid();
    logic [6:0] hs;
    bus.req_valid = 1; bus.req_we = 0; bus.req_addr = 32'h8000_0080;
    step();
    bus.req_valid = 0; bus.arready = 1;
    step();
    bus.arready = 0;
    n_checks++; if (bus.rready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_rd_data: got rready=%b, expected 1", bus.rready); end
    #3;
    rst_n = 1'b0;
    #1;
    hs = {bus.req_ready, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready, bus.rsp_valid};
    n_checks++; if (hs !== 7'b0) begin n_fail++; $display("FAIL rstmid_async: got %b, expected 0000000", hs); end
    n_checks++; if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL rstmid_state: got %0d, expected 0", dbg_state); end
    step();
    rst_n = 1'b1;
    bus.rvalid = 1; bus.rdata = 32'hFFFF_0000;
    step();
    n_checks++; if ({bus.req_ready, bus.rsp_valid, bus.rready} !== 3'b100) begin n_fail++; $display("FAIL rstmid_release: got req_ready/rsp/r=%b, expected 100", {bus.req_ready, bus.rsp_valid, bus.rready}); end
    step();
    n_checks++; if ({bus.rsp_valid, bus.rsp_rdata, dbg_state} !== {1'b0, 32'h0, 3'd0}) begin n_fail++; $display("FAIL rstmid_spurious_r: got rsp=%b data=%h state=%0d, expected 0/0/0", bus.rsp_valid, bus.rsp_rdata, dbg_state); end
    bus.rvalid = 0; bus.rdata = 32'h0;
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_read_latency();
    test_write_split();
    test_write_aw_first();
    test_error_resp();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/axil_master_bridge.md
Name: axil_master_bridge

Overview:
- AXI-lite initiator that converts the core's single-outstanding load/store request interface into AXI-lite AR/R/AW/W/B channel traffic.
- Sits between the LSU (or IFU) and an AXI-lite responder such as the instruction/data SRAM model.
- Keeps one transaction in flight at a time and returns read data and error status to the core through a valid/ready response port.

Parameters:
- ADDR_W, 32, AXI address width (matches `AXI_ADDR_BUS)
- DATA_W, 32, AXI data width (matches `AXI_DATA_BUS); WSTRB width = DATA_W/8

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  1  core request valid
- req_ready  out  1  bridge can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  request byte address
- req_wdata  in  DATA_W  write data
- req_wstrb  in  DATA_W/8  write byte strobes
- rsp_valid  out  1  response valid
- rsp_ready  in  1  core accepts response
- rsp_rdata  out  DATA_W  read data (0 for writes)
- rsp_err  out  1  1 if RRESP/BRESP was not OKAY
- araddr  out  ADDR_W  AR address
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rdata  in  DATA_W  R data
- rresp  in  2  R response
- rvalid  in  1  R valid
- rready  out  1  R ready
- awaddr  out  ADDR_W  AW address
- awvalid  out  1  AW valid
- awready  in  1  AW ready
- wdata  out  DATA_W  W data
- wstrb  out  DATA_W/8  W strobes
- wvalid  out  1  W valid
- wready  in  1  W ready
- bresp  in  2  B response
- bvalid  in  1  B valid
- bready  out  1  B ready

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE; all valid/ready outputs 0 immediately, except req_ready=0 while rst_n=0.
  - araddr/awaddr/wdata/wstrb/rsp_rdata = 0; rsp_err = 0.
  - Reset asserted mid-transaction abandons it; no response is issued after release.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch addr/wdata/wstrb/we.
  - Next state is WR_REQ if we=1, else RD_ADDR.
- RD_ADDR:
  - arvalid=1; araddr = latched address.
  - araddr is held stable and arvalid is never dropped until arready is sampled high.
  - Handshake -> RD_DATA.
- RD_DATA:
  - rready=1.
  - On rvalid: capture rsp_rdata=rdata and rsp_err=(rresp!=2'b00), then -> RESP.
- WR_REQ:
  - awvalid and wvalid are asserted in the same cycle.
  - Each channel deasserts independently, the cycle after its own handshake; tracked by aw_done and w_done flags.
  - AW and W may complete in either order or in the same cycle.
  - When both are done -> WR_RESP.
  - awaddr/wdata/wstrb are held stable while their valid is high.
- WR_RESP:
  - bready=1.
  - On bvalid: rsp_rdata=0, rsp_err=(bresp!=2'b00), then -> RESP.
- RESP:
  - rsp_valid=1, held with stable data until rsp_ready.
  - Handshake -> IDLE.
  - A new request can be accepted in the cycle following the handshake.
- All AXI outputs are registered (no combinational path from AXI inputs to AXI outputs). req_ready is decoded from state.
- Minimum latency with a zero-wait responder: request accepted at cycle 0, arvalid at 1, rready at 2, rsp_valid at 3.
- Addresses and strobes pass through unmodified; no alignment check.
- wstrb=0 still issues a full AW/W/B sequence.
- rready and bready are asserted only in their wait states, so a spurious rvalid or bvalid in any other state is ignored.
- req_valid outside IDLE is ignored (req_ready=0).
- No timeout; the bridge waits indefinitely on the responder.

Test Plan:
1. Read, zero-wait responder: req addr=0x8000_0000; responder returns rdata=0x0000_0413, rresp=00 -> arvalid at cycle 1, rsp_valid at cycle 3, rsp_rdata=0x0000_0413, rsp_err=0.
2. Read with latency: arready delayed 3 cycles, rvalid delayed 5 cycles -> araddr stable and arvalid held throughout the wait; rsp_valid exactly 1 cycle after the R handshake.
3. Write, split channels: addr=0x8000_0010, wdata=0xDEAD_BEEF, wstrb=0xF; wready at cycle 1, awready at cycle 4 -> wvalid drops after cycle 1, awvalid held until cycle 4, bready only after both handshakes; bresp=00 -> rsp_err=0, rsp_rdata=0.
4. Error responses: rresp=2'b10 on a read, then bresp=2'b11 on a write -> rsp_err=1 for both.
5. Response backpressure: rsp_ready held low for 4 cycles -> rsp_valid and data stable, req_ready=0; rsp_ready high -> IDLE and back-to-back next request accepted.
6. Reset mid-transaction: rst_n low while in RD_DATA -> all valid/ready outputs low asynchronously; after release the bridge is in IDLE with req_ready=1 and no rsp_valid.
